// File: rtl/int_to_fp_converter.sv
// Signed integer to packed {sign, exp, fraction} float converter for fp_adder operands.
// Normalizes one bit per cycle, so latency depends on the operand's leading zeros.
module int_to_fp_converter #(
  parameter int INT_WIDTH      = 32,
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic [INT_WIDTH-1:0]                int_in,
  input  logic                                valid_in,
  output logic                                ready_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0]   fp_out,
  output logic                                valid_out,
  input  logic                                ready_in
);

  localparam int KW      = $clog2(INT_WIDTH);
  localparam int BIAS    = 2 ** (EXP_WIDTH - 1) - 1;
  localparam int EXP_TOP = BIAS + INT_WIDTH - 1;
  localparam logic [EXP_WIDTH-1:0] EXP_TOP_V = EXP_WIDTH'(EXP_TOP);

  if (EXP_TOP > 2 ** EXP_WIDTH - 2) begin : g_bad_params
    $error("int_to_fp_converter: exponent field too narrow for INT_WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_NORM,
    S_PACK,
    S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [INT_WIDTH-1:0]      r_int;
  logic [INT_WIDTH-1:0]      r_mag;
  logic                      r_sign;
  logic [KW-1:0]             r_k;
  logic [INT_WIDTH-1:0]      w_abs;
  logic [EXP_WIDTH-1:0]      w_exp;
  logic [MANTISSA_WIDTH-1:0] w_mant;

  // Negating the most negative value wraps to 2^(INT_WIDTH-1), which is its true magnitude.
  assign w_abs = r_sign ? (-r_int) : r_int;
  assign w_exp = EXP_TOP_V - EXP_WIDTH'(r_k);

  if (INT_WIDTH - 1 >= MANTISSA_WIDTH) begin : g_mant_trunc
    assign w_mant = r_mag[INT_WIDTH-2 -: MANTISSA_WIDTH];
  end else begin : g_mant_pad
    assign w_mant = {r_mag[INT_WIDTH-2:0], {(MANTISSA_WIDTH - INT_WIDTH + 1){1'b0}}};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A zero magnitude skips NORM and goes straight to PACK, which packs it as +0.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (valid_in) w_next = S_ABS;
      S_ABS:  w_next = (w_abs == '0) ? S_PACK : S_NORM;
      S_NORM: if (r_mag[INT_WIDTH-1]) w_next = S_PACK;
      S_PACK: w_next = S_DONE;
      S_DONE: if (ready_in) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_int  <= '0;
      r_sign <= 1'b0;
      r_mag  <= '0;
      r_k    <= '0;
      fp_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            r_int  <= int_in;
            r_sign <= int_in[INT_WIDTH-1];
            r_k    <= '0;
          end
        end
        S_ABS: begin
          r_mag <= w_abs;
        end
        S_NORM: begin
          if (!r_mag[INT_WIDTH-1]) begin
            r_mag <= r_mag << 1;
            r_k   <= r_k + 1'b1;
          end
        end
        S_PACK: begin
          // In PACK the MSB is clear only for a zero operand.
          if (r_mag[INT_WIDTH-1]) begin
            fp_out <= {r_sign, w_exp, w_mant};
          end else begin
            fp_out <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_out = (r_state == S_IDLE);
  assign valid_out = (r_state == S_DONE);

endmodule

// File: tb/tb_int_to_fp_converter.sv
// Self-checking bench for int_to_fp_converter: directed corners, backpressure,
// mid-operation reset and a randomized sweep against an arithmetic float model.
module tb_int_to_fp_converter;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [31:0] int_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] fp_out;
  logic        valid_out;
  logic        ready_in;

  int total = 0;
  int bad   = 0;

  int_to_fp_converter #(
    .INT_WIDTH(32),
    .EXP_WIDTH(8),
    .MANTISSA_WIDTH(23)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .int_in   (int_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .fp_out   (fp_out),
    .valid_out(valid_out),
    .ready_in (ready_in)
  );

  always #5 clk_in = ~clk_in;

  function automatic longint ref_mag(input logic [31:0] v);
    longint m;
    m = longint'($signed(v));
    if (m < 0) m = -m;
    return m;
  endfunction

  function automatic int ref_msb(input longint m);
    int p;
    p = 0;
    for (int i = 0; i < 63; i++) if (m[i]) p = i;
    return p;
  endfunction

  // Truncating int-to-single conversion from the value's binary magnitude.
  function automatic logic [31:0] ref_fp(input logic [31:0] v);
    longint m;
    longint frac;
    int     p;
    logic [7:0] e;
    if (v == 32'h0) return 32'h0;
    m    = ref_mag(v);
    p    = ref_msb(m);
    frac = m - (longint'(1) << p);
    if (p >= 23) frac = frac >> (p - 23);
    else         frac = frac << (23 - p);
    e = 8'(127 + p);
    return {v[31], e, frac[22:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] v);
    if (v == 32'h0) return 2;
    return (31 - ref_msb(ref_mag(v))) + 3;
  endfunction

  // Drives one operand, measures edges to valid_out, then stalls randomly before accepting.
  task automatic run_op(input logic [31:0] v, input int stall_max,
                        output logic [31:0] res, output int lat);
    int n;
    int_in   = v;
    valid_in = 1'b1;
    ready_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    valid_in = 1'b0;
    int_in   = $urandom;
    lat = 0;
    while (!valid_out && lat < 100) begin
      @(posedge clk_in);
      lat++;
      @(negedge clk_in);
    end
    if (!valid_out) begin
      total++;
      bad++;
      $display("FAIL timeout v=%h: valid_out got 0 want 1 within 100 edges", v);
    end
    res = fp_out;
    n = (stall_max > 0) ? $urandom_range(0, stall_max) : 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      @(negedge clk_in);
    end
    ready_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    int_in   = 32'h0;
    #2;
    total++;
    if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_out); end
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    total++;
    if (fp_out !== 32'h0) begin bad++; $display("FAIL reset_fp: got %h want 00000000", fp_out); end
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] vals [6] = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'd10, 32'h8000_0000, 32'd16777217};
    logic [31:0] exps [6] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0, 32'h4120_0000,
                              32'hCF00_0000, 32'h4B80_0000};
    int          lats [6] = '{34, 34, 2, 31, 3, 10};
    logic [31:0] res;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(vals[i], 0, res, lat);
      total++;
      if (res !== exps[i]) begin
        bad++;
        $display("FAIL directed_fp v=%h: got %h want %h", vals[i], res, exps[i]);
      end
      total++;
      if (lat != lats[i]) begin
        bad++;
        $display("FAIL directed_lat v=%h: got %0d want %0d", vals[i], lat, lats[i]);
      end
      total++;
      if (ready_out !== 1'b1) begin
        bad++;
        $display("FAIL directed_ready v=%h: got %b want 1", vals[i], ready_out);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    int_in   = 32'd10;
    valid_in = 1'b1;
    ready_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    valid_in = 1'b0;
    guard = 0;
    while (!valid_out && guard < 100) begin
      @(posedge clk_in);
      @(negedge clk_in);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'($urandom);
      int_in   = $urandom;
      @(posedge clk_in);
      @(negedge clk_in);
      total++;
      if (valid_out !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d: got %b want 1", i, valid_out); end
      total++;
      if (fp_out !== 32'h4120_0000) begin bad++; $display("FAIL bp_fp cyc=%0d: got %h want 41200000", i, fp_out); end
      total++;
      if (ready_out !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d: got %b want 0", i, ready_out); end
    end
    ready_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    ready_in = 1'b0;
    valid_in = 1'b0;
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", valid_out); end
    total++;
    if (ready_out !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", ready_out); end
  endtask

  task automatic test_midreset();
    logic [31:0] res;
    int          lat;
    int_in   = 32'd1;
    valid_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in);
      @(negedge clk_in);
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", valid_out); end
    total++;
    if (fp_out !== 32'h0) begin bad++; $display("FAIL midrst_fp: got %h want 00000000", fp_out); end
    total++;
    if (ready_out !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", ready_out); end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    run_op(32'd10, 0, res, lat);
    total++;
    if (res !== 32'h4120_0000) begin bad++; $display("FAIL midrst_after_fp: got %h want 41200000", res); end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [31:0] res;
    int          lat;
    for (int i = 0; i < 2000; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      if (i % 97 == 0) v = 32'h0;
      run_op(v, 3, res, lat);
      total++;
      if (res !== ref_fp(v)) begin
        bad++;
        $display("FAIL random_fp v=%h: got %h want %h", v, res, ref_fp(v));
      end
      total++;
      if (lat != ref_lat(v)) begin
        bad++;
        $display("FAIL random_lat v=%h: got %0d want %0d", v, lat, ref_lat(v));
      end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk_in);
    test_directed();
    test_backpressure();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
